// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding data-bus access at a time.
// Formats store byte lanes and strobes on the way out.
// Aligns and sign- or zero-extends load data on the way back.
// Holds the upstream pipeline with stall while an access is in flight.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Everything the bus needs, latched once at issue so dbus_* stay stable.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  funct3;
  } lsu_req_t;

  state_t        state;
  lsu_req_t      req_q;
  logic [CW-1:0] cnt;
  logic          kill_q;

  size_t         sz;
  logic          is_mem, mis, start;
  logic [31:0]   wd_n;
  logic [3:0]    ws_n;
  logic [31:0]   shifted, fmt;

  assign is_mem = in_load | in_store;

  // Access size; BU/HU map onto B/H, the unused encodings fall back to word.
  always_comb begin
    sz = SZ_W;
    case (in_funct3)
      3'b000, 3'b100: sz = SZ_B;
      3'b001, 3'b101: sz = SZ_H;
      default:        sz = SZ_W;
    endcase
  end

  assign mis   = ((sz == SZ_H) && in_addr[0]) || ((sz == SZ_W) && (in_addr[1:0] != 2'b00));
  assign start = (state == IDLE) && in_valid && is_mem && !mis && !flush;

  // Store lane replication and byte strobes for the addressed lanes.
  always_comb begin
    wd_n = in_wdata;
    ws_n = 4'b1111;
    case (sz)
      SZ_B: begin
        wd_n = {4{in_wdata[7:0]}};
        ws_n = 4'b0001 << in_addr[1:0];
      end
      SZ_H: begin
        wd_n = {2{in_wdata[15:0]}};
        ws_n = 4'b0011 << in_addr[1:0];
      end
      default: begin
        wd_n = in_wdata;
        ws_n = 4'b1111;
      end
    endcase
  end

  // Right-align the addressed bytes of the read word, then extend.
  assign shifted = dbus_rdata >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    fmt = shifted;
    case (req_q.funct3)
      3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  fmt = {24'h0, shifted[7:0]};
      3'b101:  fmt = {16'h0, shifted[15:0]};
      default: fmt = shifted;
    endcase
  end

  // Pipeline handshake. Non-memory and misaligned ops pass straight through in IDLE.
  always_comb begin
    stall     = start || (state == REQ);
    out_valid = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        misalign  = in_valid && is_mem && mis && !flush;
        out_valid = in_valid && !flush && (!is_mem || mis);
      end
      RESP:    out_valid = !kill_q && !flush;
      default: out_valid = 1'b0;
    endcase
  end

  assign dbus_we    = req_q.we;
  assign dbus_addr  = {req_q.addr[31:2], 2'b00};
  assign dbus_wdata = req_q.wdata;
  assign dbus_wstrb = req_q.wstrb;

  // Access FSM. The result stays in RESP for exactly one cycle, then everything clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      dbus_req  <= 1'b0;
      load_data <= 32'h0;
      bus_err   <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_q.we     <= in_store;
            req_q.addr   <= in_addr;
            req_q.wdata  <= in_store ? wd_n : 32'h0;
            req_q.wstrb  <= in_store ? ws_n : 4'b0000;
            req_q.funct3 <= in_funct3;
            dbus_req     <= 1'b1;
            cnt          <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          // A flushed access still completes on the bus; only its result is dropped.
          if (flush) kill_q <= 1'b1;
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            cnt      <= '0;
            if (!req_q.we) load_data <= fmt;
            state    <= RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
            cnt      <= '0;
            state    <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          load_data <= 32'h0;
          bus_err   <= 1'b0;
          kill_q    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
